// File: rtl/sbox_pipe_if.sv
// Byte-lane stream bundle for the S-box pipe.
// master drives valid/data/inv, slave drives ready.
interface sbox_pipe_if #(
  parameter int LANES = 16
);
  logic                 valid;
  logic                 ready;
  logic [8*LANES-1:0]   data;
  logic                 inv;

  modport master (
    output valid, data, inv,
    input  ready
  );

  modport slave (
    input  valid, data, inv,
    output ready
  );
endinterface

// File: rtl/sbox_pipe.sv
// Pipelined multi-lane AES SubBytes engine; in_s/out_s streams, busy flag.
// INV_SBOX_EN adds the per-beat selectable inverse S-box.
module sbox_pipe #(
  parameter int LANES      = 16,
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sbox_pipe_if.slave  in_s,
  sbox_pipe_if.master out_s,
  output logic        busy
);
  localparam int W = 8 * LANES;
  localparam int L = PIPE_DEPTH - 1;

  function automatic logic [7:0] rl(
    logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(
    logic [7:0] a);
    return {a[6:0], 1'b0}
         ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); maps 0 to 0
  function automatic logic [7:0] ginv(
    logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] fsb(
    logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rl(y, 1) ^ rl(y, 2)
         ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
  endfunction

`ifdef INV_SBOX_EN
  function automatic logic [7:0] isb(
    logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3)
              ^ rl(x, 6) ^ 8'h05);
  endfunction
`endif

  logic [W-1:0]          lk;
  logic                  inv_in;
  logic [PIPE_DEPTH-1:0] v;
  logic [PIPE_DEPTH-1:0] adv;
  logic [PIPE_DEPTH-1:0] f;
  logic [W-1:0]          d [PIPE_DEPTH];

`ifdef INV_SBOX_EN
  assign inv_in = in_s.inv;
`else
  logic unused_inv;
  assign unused_inv = in_s.inv;
  assign inv_in     = 1'b0;
`endif

  // One independent table per lane,
  // captured by stage 0 as a registered ROM read
  always_comb begin
    lk = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef INV_SBOX_EN
      lk[8*i +: 8] = inv_in
        ? isb(in_s.data[8*i +: 8])
        : fsb(in_s.data[8*i +: 8]);
`else
      lk[8*i +: 8] = fsb(in_s.data[8*i +: 8]);
`endif
    end
  end

  // A stage may move when it is empty or
  // everything after it can move
  always_comb begin : adv_chain
    logic a;
    adv    = '0;
    a      = !v[L] | out_s.ready;
    adv[L] = a;
    for (int k = L - 1; k >= 0; k--) begin
      a      = !v[k] | a;
      adv[k] = a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      f <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++)
        d[k] <= '0;
    end else begin
      if (adv[0])
        v[0] <= in_s.valid;
      if (adv[0] && in_s.valid) begin
        d[0] <= lk;
        f[0] <= inv_in;
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (adv[k])
          v[k] <= v[k-1];
        if (adv[k] && v[k-1]) begin
          d[k] <= d[k-1];
          f[k] <= f[k-1];
        end
      end
    end
  end

  assign in_s.ready = adv[0];
  assign out_s.valid = v[L];
  assign out_s.data  = d[L];
  assign out_s.inv   = f[L];
  assign busy        = |v;
endmodule

// File: tb/tb_sbox_pipe.sv
// Scoreboard bench for sbox_pipe against a
// generator-built S-box table model.
module tb_sbox_pipe #(
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 2
);
  localparam int W = 8 * LANES;
`ifdef INV_SBOX_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         i;
  } beat_t;

  logic clk;
  logic rst_n;
  logic busy;

  sbox_pipe_if #(.LANES(LANES)) in_s ();
  sbox_pipe_if #(.LANES(LANES)) out_s ();

  sbox_pipe #(
    .LANES(LANES),
    .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in_s (in_s),
    .out_s(out_s),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    out_cnt = 0;
  int    first_cyc = -1;
  int    last_cyc = -1;
  logic  acc;
  logic  rdy_s;
  logic  held = 1'b0;
  logic [W-1:0] held_d;
  logic  held_i;
  logic [7:0] fs [256];
  logic [7:0] is_ [256];
  beat_t sb [$];
  beat_t stim [$];

  function automatic void chk(string n,
    logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               n, a, e);
    end
  endfunction

  function automatic logic [7:0] rot(
    logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Classic generator walk over GF(2^8)*
  function automatic void build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rot(q, 1) ^ rot(q, 2)
        ^ rot(q, 3) ^ rot(q, 4);
      fs[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fs[0] = 8'h63;
    for (int i = 0; i < 256; i++)
      is_[fs[i]] = i[7:0];
  endfunction

  function automatic beat_t model(beat_t b);
    beat_t r;
    r.i = INV_EN & b.i;
    r.d = '0;
    for (int k = 0; k < LANES; k++)
      r.d[8*k +: 8] = r.i ? is_[b.d[8*k +: 8]]
                          : fs[b.d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = 8'($urandom_range(255));
    return r;
  endfunction

  // Monitor + scoreboard, all sampled mid-cycle
  always @(negedge clk) begin
    beat_t e;
    beat_t ib;
    cyc++;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready_occ", in_s.ready,
          out_s.ready || sb.size() < PIPE_DEPTH);
      chk("busy_occ", busy, sb.size() != 0);
      if (held) begin
        chk("hold_valid", out_s.valid, 1'b1);
        chk("hold_data", out_s.data, held_d);
        chk("hold_inv", out_s.inv, held_i);
      end
      if (out_s.valid && out_s.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_s.data, e.d);
          chk("out_inv", out_s.inv, e.i);
        end
        out_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      held   = out_s.valid && !out_s.ready;
      held_d = out_s.data;
      held_i = out_s.inv;
      if (in_s.valid && in_s.ready) begin
        ib.d = in_s.data;
        ib.i = in_s.inv;
        sb.push_back(model(ib));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    acc   = in_s.valid && in_s.ready;
    rdy_s = in_s.ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int pv, input int pr);
    int g;
    g = 0;
    while (stim.size() != 0 && g < 20000) begin
      in_s.valid = ($urandom_range(99) < pv);
      in_s.data  = in_s.valid ? stim[0].d : rnd_data();
      in_s.inv   = in_s.valid ? stim[0].i : 1'($urandom_range(1));
      out_s.ready = ($urandom_range(99) < pr);
      step();
      if (acc) void'(stim.pop_front());
      g++;
    end
    chk("drive_budget", stim.size() == 0, 1'b1);
    in_s.valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_s.valid  = 1'b0;
    out_s.ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size() == 0 && !busy, 1'b1);
  endtask

  initial begin
    beat_t b;
    logic [7:0] ip [4];
    logic [7:0] ep [4];
    logic [7:0] vp [4];
    logic [W-1:0] pat, expd;
    int c;

    build_tables();
    ip = '{8'hff, 8'h53, 8'h01, 8'h00};
    ep = '{8'h16, 8'hed, 8'h7c, 8'h63};
    vp = '{8'h00, 8'h16, 8'hed, 8'h63};
    rst_n       = 1'b0;
    in_s.valid  = 1'b0;
    in_s.data   = '0;
    in_s.inv    = 1'b0;
    out_s.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_s.valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_s.data, '0);
    chk("rst_out_inv", out_s.inv, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_s.ready, 1'b1);

    // single beat latency and known values
    for (int k = 0; k < LANES; k++) begin
      pat[8*k +: 8]  = ip[k % 4];
      expd[8*k +: 8] = ep[k % 4];
    end
    in_s.valid  = 1'b1;
    in_s.data   = pat;
    in_s.inv    = 1'b0;
    out_s.ready = 1'b1;
    step();
    chk("t1_accept", acc, 1'b1);
    in_s.valid = 1'b0;
    for (int j = 0; j <= PIPE_DEPTH; j++) begin
      @(negedge clk);
      chk("t1_out_valid", out_s.valid,
          j == PIPE_DEPTH - 1);
      chk("t1_busy", busy, j < PIPE_DEPTH);
      if (j == PIPE_DEPTH - 1)
        chk("t1_data", out_s.data, expd);
    end
    @(posedge clk);
    #1;

    // all byte values back-to-back, no gaps
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < LANES; k++)
        b.d[8*k +: 8] = v[7:0];
      b.i = 1'b0;
      stim.push_back(b);
    end
    out_cnt   = 0;
    first_cyc = -1;
    drive(100, 100);
    drain();
    chk("t2_count", out_cnt, 256);
    chk("t2_no_gap", last_cyc - first_cyc, 255);

    // backpressure window
    for (int v = 0; v < 8; v++) begin
      b.d = rnd_data();
      b.i = 1'($urandom_range(1));
      stim.push_back(b);
    end
    out_cnt = 0;
    c = 0;
    while (stim.size() != 0 && c < 100) begin
      in_s.valid  = 1'b1;
      in_s.data   = stim[0].d;
      in_s.inv    = stim[0].i;
      out_s.ready = !(c >= 3 && c <= 7);
      step();
      if (c == 7) chk("t3_in_ready", rdy_s, 1'b0);
      if (acc) void'(stim.pop_front());
      c++;
    end
    drain();
    chk("t3_count", out_cnt, 8);

    // reset with beats in flight
    out_s.ready = 1'b0;
    for (int v = 0; v < 2; v++) begin
      in_s.valid = 1'b1;
      in_s.data  = rnd_data();
      step();
    end
    in_s.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t4_out_valid", out_s.valid, 1'b0);
    chk("t4_busy", busy, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_cnt = 0;
    b.d = rnd_data();
    b.i = 1'b0;
    stim.push_back(b);
    drive(100, 100);
    drain();
    chk("t4_count", out_cnt, 1);

`ifdef INV_SBOX_EN
    // alternating inverse / forward beats
    for (int k = 0; k < LANES; k++)
      pat[8*k +: 8] = vp[k % 4];
    for (int v = 0; v < 8; v++) begin
      b.d = pat;
      b.i = v[0];
      stim.push_back(b);
    end
    drive(100, 100);
    drain();
`endif

    // random traffic both sides
    for (int v = 0; v < 1500; v++) begin
      b.d = rnd_data();
      b.i = 1'($urandom_range(1));
      stim.push_back(b);
    end
    out_cnt = 0;
    drive(70, 60);
    drain();
    chk("t6_count", out_cnt, 1500);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
